dmem_channel_arbiter: RTL and testbench

//  Sits directly downstream of the data-memory cache. Merges its NUM_CHANNELS

---
 rtl/dmem_channel_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_dmem_channel_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_channel_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dmem_channel_arbiter                                           |
// | Purpose : Round-robin merge of per-channel read/write handshakes from    |
// |           the data-memory cache onto one single-port external bus, one   |
// |           transaction outstanding, 1-cycle ready pulse back to the       |
// |           granted channel.                                               |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module dmem_channel_arbiter #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [NUM_CHANNELS-1:0]                ch_read_valid_i,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] ch_read_address_i,
  output logic [NUM_CHANNELS-1:0]                ch_read_ready_o,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] ch_read_data_o,
  input  logic [NUM_CHANNELS-1:0]                ch_write_valid_i,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] ch_write_address_i,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] ch_write_data_i,
  output logic [NUM_CHANNELS-1:0]                ch_write_ready_o,
  output logic                                   ext_valid_o,
  output logic                                   ext_we_o,
  output logic [ADDR_BITS-1:0]                   ext_address_o,
  output logic [DATA_BITS-1:0]                   ext_wdata_o,
  input  logic                                   ext_ready_i,
  input  logic                                   ext_rvalid_i,
  input  logic [DATA_BITS-1:0]                   ext_rdata_i
);

  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_RESP = 3'd2,
    S_RESPOND   = 3'd3,
    S_COOLDOWN  = 3'd4
  } state_t;

  state_t                                 state_q, state_d;
  logic [IDX_W-1:0]                       grant_q, grant_d;
  logic [IDX_W-1:0]                       rr_ptr_q, rr_ptr_d;
  logic                                   ext_valid_q, ext_valid_d;
  logic                                   ext_we_q, ext_we_d;
  logic [ADDR_BITS-1:0]                   ext_address_q, ext_address_d;
  logic [DATA_BITS-1:0]                   ext_wdata_q, ext_wdata_d;
  logic [NUM_CHANNELS-1:0]                rd_ready_q, rd_ready_d;
  logic [NUM_CHANNELS-1:0]                wr_ready_q, wr_ready_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] rd_data_q, rd_data_d;

  logic [NUM_CHANNELS-1:0]                req;
  logic                                   arb_found;
  logic [IDX_W-1:0]                       arb_pick;

  // Channel index that is k positions after ptr, wrapping at NUM_CHANNELS.
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] ptr, input int k);
    logic [IDX_W:0] sum;
    sum = {1'b0, ptr} + (IDX_W+1)'(k);
    if (sum >= (IDX_W+1)'(NUM_CHANNELS)) begin
      sum = sum - (IDX_W+1)'(NUM_CHANNELS);
    end
    return sum[IDX_W-1:0];
  endfunction

  assign req = ch_read_valid_i | ch_write_valid_i;

  // Round-robin search: first requester at or after rr_ptr.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (!arb_found && req[rr_index(rr_ptr_q, k)]) begin
        arb_found = 1'b1;
        arb_pick  = rr_index(rr_ptr_q, k);
      end
    end
  end

  // Next-state and registered-output logic; ready pulses default low.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    ext_valid_d   = ext_valid_q;
    ext_we_d      = ext_we_q;
    ext_address_d = ext_address_q;
    ext_wdata_d   = ext_wdata_q;
    rd_ready_d    = '0;
    wr_ready_d    = '0;
    rd_data_d     = rd_data_q;

    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          grant_d     = arb_pick;
          ext_valid_d = 1'b1;
          // A channel asking for both is served as a read first.
          ext_we_d    = ~ch_read_valid_i[arb_pick];
          ext_address_d = ch_read_valid_i[arb_pick] ? ch_read_address_i[arb_pick]
                                                    : ch_write_address_i[arb_pick];
          ext_wdata_d = ch_write_data_i[arb_pick];
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (ext_ready_i) begin
          ext_valid_d = 1'b0;
          if (ext_we_q) begin
            wr_ready_d[grant_q] = 1'b1;
            state_d             = S_RESPOND;
          end else if (ext_rvalid_i) begin
            rd_data_d[grant_q]  = ext_rdata_i;
            rd_ready_d[grant_q] = 1'b1;
            state_d             = S_RESPOND;
          end else begin
            state_d = S_WAIT_RESP;
          end
        end
      end

      S_WAIT_RESP: begin
        if (ext_rvalid_i) begin
          rd_data_d[grant_q]  = ext_rdata_i;
          rd_ready_d[grant_q] = 1'b1;
          state_d             = S_RESPOND;
        end
      end

      S_RESPOND: begin
        // Served channel drops to lowest priority.
        rr_ptr_d = (grant_q == IDX_W'(NUM_CHANNELS - 1)) ? '0 : grant_q + IDX_W'(1);
        state_d  = S_COOLDOWN;
      end

      // The just-served channel may still show valid here; skip a cycle.
      S_COOLDOWN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; async reset abandons any transaction in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      ext_valid_q   <= 1'b0;
      ext_we_q      <= 1'b0;
      ext_address_q <= '0;
      ext_wdata_q   <= '0;
      rd_ready_q    <= '0;
      wr_ready_q    <= '0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      ext_valid_q   <= ext_valid_d;
      ext_we_q      <= ext_we_d;
      ext_address_q <= ext_address_d;
      ext_wdata_q   <= ext_wdata_d;
      rd_ready_q    <= rd_ready_d;
      wr_ready_q    <= wr_ready_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign ext_valid_o      = ext_valid_q;
  assign ext_we_o         = ext_we_q;
  assign ext_address_o    = ext_address_q;
  assign ext_wdata_o      = ext_wdata_q;
  assign ch_read_ready_o  = rd_ready_q;
  assign ch_write_ready_o = wr_ready_q;
  assign ch_read_data_o   = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_channel_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_dmem_channel_arbiter                                        |
// | Purpose : Directed, table-driven self-checking bench for the channel     |
// |           arbiter (4 channels, 8-bit address and data).                  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_dmem_channel_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         rv, wv, rrdy, wrdy;
  logic [N-1:0][AW-1:0] ra, wa;
  logic [N-1:0][DW-1:0] wd, rdata;
  logic                 ext_valid, ext_we, er, ev;
  logic [AW-1:0]        ext_address;
  logic [DW-1:0]        ext_wdata, ed;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dmem_channel_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CHANNELS(N)) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .ch_read_valid_i    (rv),
    .ch_read_address_i  (ra),
    .ch_read_ready_o    (rrdy),
    .ch_read_data_o     (rdata),
    .ch_write_valid_i   (wv),
    .ch_write_address_i (wa),
    .ch_write_data_i    (wd),
    .ch_write_ready_o   (wrdy),
    .ext_valid_o        (ext_valid),
    .ext_we_o           (ext_we),
    .ext_address_o      (ext_address),
    .ext_wdata_o        (ext_wdata),
    .ext_ready_i        (er),
    .ext_rvalid_i       (ev),
    .ext_rdata_i        (ed)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  rv, wv;
    logic        er, ev;
    logic [7:0]  ed;
    logic        x_valid, x_we;
    logic [7:0]  x_addr, x_wdata;
    logic [3:0]  x_rrdy, x_wrdy;
    logic [31:0] x_rdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] r, input logic [3:0] w,
                              input logic e_r, input logic e_v, input logic [7:0] e_d,
                              input logic xv, input logic xwe, input logic [7:0] xa,
                              input logic [7:0] xwd, input logic [3:0] xrr,
                              input logic [3:0] xwr, input logic [31:0] xrd);
    vec_t v;
    v.rst = rst; v.rv = r; v.wv = w; v.er = e_r; v.ev = e_v; v.ed = e_d;
    v.x_valid = xv; v.x_we = xwe; v.x_addr = xa; v.x_wdata = xwd;
    v.x_rrdy = xrr; v.x_wrdy = xwr; v.x_rdata = xrd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    vec_t v;
    int   lat;

    // Fixed per-channel addresses/data: read 0x39+i, write 0x0E+i, wdata 0xA3+i.
    ra = {8'h3C, 8'h3B, 8'h3A, 8'h39};
    wa = {8'h11, 8'h10, 8'h0F, 8'h0E};
    wd = {8'hA6, 8'hA5, 8'hA4, 8'hA3};
    reset = 1'b1; rv = '0; wv = '0; er = 1'b0; ev = 1'b0; ed = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ext_valid", 32'(ext_valid), 0);
    chk("rst.ext_we", 32'(ext_we), 0);
    chk("rst.ext_address", 32'(ext_address), 0);
    chk("rst.ext_wdata", 32'(ext_wdata), 0);
    chk("rst.rd_ready", 32'(rrdy), 0);
    chk("rst.wr_ready", 32'(wrdy), 0);
    chk("rst.rd_data", 32'(rdata), 0);
    reset = 1'b0;

    // Reset while the request is on the bus: abandoned, no pulse, back to idle
    rv = 4'b0001;
    @(posedge clk); #1;
    chk("t1.issue_valid", 32'(ext_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("t1.valid_drop", 32'(ext_valid), 0);
    chk("t1.no_rrdy", 32'(rrdy), 0);
    rv = '0;
    #2 reset = 1'b0;
    er = 1'b1; ev = 1'b1; ed = 8'hBB;
    @(posedge clk); #1;
    chk("t1.idle_valid", 32'(ext_valid), 0);
    chk("t1.idle_rrdy", 32'(rrdy), 0);
    chk("t1.idle_rdata", 32'(rdata), 0);
    er = 1'b0; ev = 1'b0; ed = '0;

    // rst, rv, wv, er, ev, ed, | valid, we, addr, wdata, rrdy, wrdy, rdata
    tbl.push_back(mk(1, 4'h0, 4'h0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 4'h0, 4'h0, 32'h0));
    // All four read at once, zero-wait memory: grants 0,1,2,3
    tbl.push_back(mk(0, 4'hF, 4'h0, 1, 1, 8'hEE, 1, 0, 8'h39, 8'h00, 4'h0, 4'h0, 32'h0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 1, 1, 8'hC0, 0, 0, 8'h39, 8'h00, 4'h1, 4'h0, 32'h000000C0));
    tbl.push_back(mk(0, 4'hE, 4'h0, 1, 1, 8'hEE, 0, 0, 8'h39, 8'h00, 4'h0, 4'h0, 32'h000000C0));
    tbl.push_back(mk(0, 4'hE, 4'h0, 1, 1, 8'hEE, 0, 0, 8'h39, 8'h00, 4'h0, 4'h0, 32'h000000C0));
    tbl.push_back(mk(0, 4'hE, 4'h0, 1, 1, 8'hEE, 1, 0, 8'h3A, 8'h00, 4'h0, 4'h0, 32'h000000C0));
    tbl.push_back(mk(0, 4'hE, 4'h0, 1, 1, 8'hC1, 0, 0, 8'h3A, 8'h00, 4'h2, 4'h0, 32'h0000C1C0));
    tbl.push_back(mk(0, 4'hC, 4'h0, 1, 1, 8'hEE, 0, 0, 8'h3A, 8'h00, 4'h0, 4'h0, 32'h0000C1C0));
    tbl.push_back(mk(0, 4'hC, 4'h0, 1, 1, 8'hEE, 0, 0, 8'h3A, 8'h00, 4'h0, 4'h0, 32'h0000C1C0));
    tbl.push_back(mk(0, 4'hC, 4'h0, 1, 1, 8'hEE, 1, 0, 8'h3B, 8'h00, 4'h0, 4'h0, 32'h0000C1C0));
    tbl.push_back(mk(0, 4'hC, 4'h0, 1, 1, 8'hC2, 0, 0, 8'h3B, 8'h00, 4'h4, 4'h0, 32'h00C2C1C0));
    tbl.push_back(mk(0, 4'h8, 4'h0, 1, 1, 8'hEE, 0, 0, 8'h3B, 8'h00, 4'h0, 4'h0, 32'h00C2C1C0));
    tbl.push_back(mk(0, 4'h8, 4'h0, 1, 1, 8'hEE, 0, 0, 8'h3B, 8'h00, 4'h0, 4'h0, 32'h00C2C1C0));
    tbl.push_back(mk(0, 4'h8, 4'h0, 1, 1, 8'hEE, 1, 0, 8'h3C, 8'h00, 4'h0, 4'h0, 32'h00C2C1C0));
    tbl.push_back(mk(0, 4'h8, 4'h0, 1, 1, 8'hC3, 0, 0, 8'h3C, 8'h00, 4'h8, 4'h0, 32'hC3C2C1C0));
    // ch3 keeps valid through the cooldown cycle: must not be re-granted
    tbl.push_back(mk(0, 4'h8, 4'h0, 0, 0, 8'h00, 0, 0, 8'h3C, 8'h00, 4'h0, 4'h0, 32'hC3C2C1C0));
    tbl.push_back(mk(0, 4'h8, 4'h0, 0, 0, 8'h00, 0, 0, 8'h3C, 8'h00, 4'h0, 4'h0, 32'hC3C2C1C0));
    tbl.push_back(mk(0, 4'h0, 4'h2, 0, 0, 8'h00, 1, 1, 8'h0F, 8'hA4, 4'h0, 4'h0, 32'hC3C2C1C0));
    tbl.push_back(mk(0, 4'h0, 4'h2, 1, 0, 8'h00, 0, 1, 8'h0F, 8'hA4, 4'h0, 4'h2, 32'hC3C2C1C0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 8'h00, 0, 1, 8'h0F, 8'hA4, 4'h0, 4'h0, 32'hC3C2C1C0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 8'h00, 0, 1, 8'h0F, 8'hA4, 4'h0, 4'h0, 32'hC3C2C1C0));
    // ch1 read 0x3A: accepted at +2, data 0x5C at +4; stray rvalid afterwards ignored
    tbl.push_back(mk(0, 4'h2, 4'h0, 0, 0, 8'h00, 1, 0, 8'h3A, 8'h00, 4'h0, 4'h0, 32'hC3C2C1C0));
    tbl.push_back(mk(0, 4'h2, 4'h0, 0, 0, 8'h00, 1, 0, 8'h3A, 8'h00, 4'h0, 4'h0, 32'hC3C2C1C0));
    tbl.push_back(mk(0, 4'h2, 4'h0, 1, 0, 8'h00, 0, 0, 8'h3A, 8'h00, 4'h0, 4'h0, 32'hC3C2C1C0));
    tbl.push_back(mk(0, 4'h2, 4'h0, 0, 0, 8'h00, 0, 0, 8'h3A, 8'h00, 4'h0, 4'h0, 32'hC3C2C1C0));
    tbl.push_back(mk(0, 4'h2, 4'h0, 0, 1, 8'h5C, 0, 0, 8'h3A, 8'h00, 4'h2, 4'h0, 32'hC3C25CC0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 8'hFF, 0, 0, 8'h3A, 8'h00, 4'h0, 4'h0, 32'hC3C25CC0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 8'hFF, 0, 0, 8'h3A, 8'h00, 4'h0, 4'h0, 32'hC3C25CC0));
    // ch2 write 0x10 <- 0xA5 with ext_ready already high
    tbl.push_back(mk(0, 4'h0, 4'h4, 1, 0, 8'h00, 1, 1, 8'h10, 8'hA5, 4'h0, 4'h0, 32'hC3C25CC0));
    tbl.push_back(mk(0, 4'h0, 4'h4, 1, 0, 8'h00, 0, 1, 8'h10, 8'hA5, 4'h0, 4'h4, 32'hC3C25CC0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 1, 0, 8'h00, 0, 1, 8'h10, 8'hA5, 4'h0, 4'h0, 32'hC3C25CC0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 8'h00, 0, 1, 8'h10, 8'hA5, 4'h0, 4'h0, 32'hC3C25CC0));
    // ch0 read+write together: read first, write on the next grant
    tbl.push_back(mk(0, 4'h1, 4'h1, 1, 1, 8'h77, 1, 0, 8'h39, 8'h00, 4'h0, 4'h0, 32'hC3C25CC0));
    tbl.push_back(mk(0, 4'h1, 4'h1, 1, 1, 8'h77, 0, 0, 8'h39, 8'h00, 4'h1, 4'h0, 32'hC3C25C77));
    tbl.push_back(mk(0, 4'h0, 4'h1, 1, 1, 8'h00, 0, 0, 8'h39, 8'h00, 4'h0, 4'h0, 32'hC3C25C77));
    tbl.push_back(mk(0, 4'h0, 4'h1, 0, 0, 8'h00, 0, 0, 8'h39, 8'h00, 4'h0, 4'h0, 32'hC3C25C77));
    tbl.push_back(mk(0, 4'h0, 4'h1, 0, 0, 8'h00, 1, 1, 8'h0E, 8'hA3, 4'h0, 4'h0, 32'hC3C25C77));
    tbl.push_back(mk(0, 4'h0, 4'h1, 1, 0, 8'h00, 0, 1, 8'h0E, 8'hA3, 4'h0, 4'h1, 32'hC3C25C77));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 8'h00, 0, 1, 8'h0E, 8'hA3, 4'h0, 4'h0, 32'hC3C25C77));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 8'h00, 0, 1, 8'h0E, 8'hA3, 4'h0, 4'h0, 32'hC3C25C77));
    // ch2 withdraws its read after grant: still completes with a pulse
    tbl.push_back(mk(0, 4'h4, 4'h0, 0, 0, 8'h00, 1, 0, 8'h3B, 8'h00, 4'h0, 4'h0, 32'hC3C25C77));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 8'h00, 1, 0, 8'h3B, 8'h00, 4'h0, 4'h0, 32'hC3C25C77));
    tbl.push_back(mk(0, 4'h0, 4'h0, 1, 0, 8'h00, 0, 0, 8'h3B, 8'h00, 4'h0, 4'h0, 32'hC3C25C77));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 8'h99, 0, 0, 8'h3B, 8'h00, 4'h4, 4'h0, 32'hC3995C77));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 8'h00, 0, 0, 8'h3B, 8'h00, 4'h0, 4'h0, 32'hC3995C77));
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 8'h00, 0, 0, 8'h3B, 8'h00, 4'h0, 4'h0, 32'hC3995C77));

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      reset = v.rst; rv = v.rv; wv = v.wv; er = v.er; ev = v.ev; ed = v.ed;
      @(posedge clk); #1;
      chk($sformatf("v%0d.ext_valid", i), 32'(ext_valid), 32'(v.x_valid));
      chk($sformatf("v%0d.ext_we", i), 32'(ext_we), 32'(v.x_we));
      chk($sformatf("v%0d.ext_address", i), 32'(ext_address), 32'(v.x_addr));
      if (v.x_we) chk($sformatf("v%0d.ext_wdata", i), 32'(ext_wdata), 32'(v.x_wdata));
      chk($sformatf("v%0d.rd_ready", i), 32'(rrdy), 32'(v.x_rrdy));
      chk($sformatf("v%0d.wr_ready", i), 32'(wrdy), 32'(v.x_wrdy));
      chk($sformatf("v%0d.rd_data", i), 32'(rdata), v.x_rdata);
    end
    reset = 1'b0;

    // Zero-wait latency: request seen -> ready pulse in 2 edges (bounded wait)
    rv = 4'b1000; wv = '0; er = 1'b1; ev = 1'b1; ed = 8'h42;
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (rrdy[3]) lat = c;
    end
    chk("lat.edges", 32'(lat), 2);
    chk("lat.rd_data3", 32'(rdata[3]), 32'h42);
    chk("lat.one_hot", 32'(rrdy), 32'h8);
    rv = '0; er = 1'b0; ev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("lat.idle_valid", 32'(ext_valid), 0);
    chk("lat.idle_rrdy", 32'(rrdy), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
